// File: rtl/cache_pkg.sv
// Shared FSM state encoding and parameter-derived widths for the N-way cache controller.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE,
    FILL
  } cache_state_e;

  function automatic int unsigned off_w(input int unsigned words);
    return $clog2(words);
  endfunction

  function automatic int unsigned idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned sets,
                                        input int unsigned words);
    return addr_w - $clog2(sets) - $clog2(words);
  endfunction

  // A 1-way cache still needs a 1-bit way select / age field.
  function automatic int unsigned way_w(input int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  function automatic int unsigned line_w(input int unsigned words);
    return 32 * words;
  endfunction

endpackage

// File: rtl/cache_sram_nway.sv
// Tag/valid/dirty/data storage: combinational read of every way of one set, single-way synchronous write.
module cache_sram_nway
  import cache_pkg::*;
#(
  parameter int unsigned WAYS   = 2,
  parameter int unsigned SETS   = 4,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned TAG_W  = 26,
  parameter int unsigned IDX_W  = idx_w(SETS),
  parameter int unsigned WAY_W  = way_w(WAYS),
  parameter int unsigned LINE_W = line_w(WORDS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [IDX_W-1:0]                  rd_index,
  output logic [WAYS-1:0]                   rd_valid,
  output logic [WAYS-1:0]                   rd_dirty,
  output logic [WAYS-1:0][TAG_W-1:0]        rd_tag,
  output logic [WAYS-1:0][LINE_W-1:0]       rd_data,
  input  logic                              wr_en,
  input  logic [WAY_W-1:0]                  wr_way,
  input  logic [IDX_W-1:0]                  wr_index,
  input  logic                              wr_valid,
  input  logic                              wr_dirty,
  input  logic [TAG_W-1:0]                  wr_tag,
  input  logic [LINE_W-1:0]                 wr_data
);

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else if (wr_en) begin
      valid_q[wr_index][wr_way] <= wr_valid;
      dirty_q[wr_index][wr_way] <= wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index][wr_way]  <= wr_tag;
      data_q[wr_index][wr_way] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];

  always_comb begin
    for (int unsigned w = 0; w < WAYS; w++) begin
      rd_tag[w]  = tag_q[rd_index][w];
      rd_data[w] = data_q[rd_index][w];
    end
  end

endmodule

// File: rtl/cache_ctrl_nway.sv
// N-way set-associative write-back/write-allocate cache controller with LRU replacement.
// Optional hit/miss counters are built when CACHE_PERF_EN is defined.
module cache_ctrl_nway
  import cache_pkg::*;
#(
  parameter int unsigned WAYS   = 2,
  parameter int unsigned SETS   = 4,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned ADDR_W = 30
) (
  input  logic                             clk,
  input  logic                             proc_reset,
  input  logic                             proc_read,
  input  logic                             proc_write,
  input  logic [ADDR_W-1:0]                proc_addr,
  input  logic [31:0]                      proc_wdata,
  output logic [31:0]                      proc_rdata,
  output logic                             proc_stall,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [ADDR_W-off_w(WORDS)-1:0]   mem_addr,
  output logic [32*WORDS-1:0]              mem_wdata,
  input  logic [32*WORDS-1:0]              mem_rdata,
  input  logic                             mem_ready
`ifdef CACHE_PERF_EN
  ,
  output logic [31:0]                      hit_cnt,
  output logic [31:0]                      miss_cnt
`endif
);

  localparam int unsigned OFF_W  = off_w(WORDS);
  localparam int unsigned IDX_W  = idx_w(SETS);
  localparam int unsigned TAG_W  = tag_w(ADDR_W, SETS, WORDS);
  localparam int unsigned WAY_W  = way_w(WAYS);
  localparam int unsigned LINE_W = line_w(WORDS);

  logic [OFF_W-1:0] offset;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic             req;

  assign offset = proc_addr[OFF_W-1:0];
  assign index  = proc_addr[OFF_W +: IDX_W];
  assign tag    = proc_addr[ADDR_W-1 -: TAG_W];
  assign req    = proc_read | proc_write;

  logic [WAYS-1:0]             rd_valid, rd_dirty;
  logic [WAYS-1:0][TAG_W-1:0]  rd_tag;
  logic [WAYS-1:0][LINE_W-1:0] rd_data;
  logic                        wr_en, wr_dirty;
  logic [WAY_W-1:0]            wr_way;
  logic [LINE_W-1:0]           wr_data;

  cache_sram_nway #(
    .WAYS  (WAYS),
    .SETS  (SETS),
    .WORDS (WORDS),
    .TAG_W (TAG_W)
  ) u_sram (
    .clk      (clk),
    .rst      (proc_reset),
    .rd_index (index),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_way   (wr_way),
    .wr_index (index),
    .wr_valid (1'b1),
    .wr_dirty (wr_dirty),
    .wr_tag   (tag),
    .wr_data  (wr_data)
  );

  cache_state_e      state_q, state_d;
  logic [WAY_W-1:0]  victim_q, victim, hit_way, lru_way;
  logic [LINE_W-1:0] line_q, base, merged;
  logic [WAY_W-1:0]  age_q [SETS][WAYS];
  logic              hit, lru_en;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (rd_valid[w] && (rd_tag[w] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Oldest way is the fallback; the downward scan leaves the lowest invalid way on top.
  always_comb begin
    victim = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (age_q[index][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
    end
    for (int unsigned w = WAYS; w > 0; w--) begin
      if (!rd_valid[w-1]) victim = WAY_W'(w - 1);
    end
  end

  always_comb begin
    base   = (state_q == FILL) ? line_q : rd_data[hit_way];
    merged = base;
    merged[{offset, 5'd0} +: 32] = proc_wdata;
  end

  always_comb begin
    state_d   = state_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = proc_addr[ADDR_W-1:OFF_W];
    wr_en     = 1'b0;
    wr_way    = hit_way;
    wr_dirty  = 1'b1;
    wr_data   = proc_write ? merged : base;
    lru_en    = 1'b0;
    lru_way   = hit_way;
    case (state_q)
      IDLE: begin
        if (req && hit) begin
          lru_en = 1'b1;
          wr_en  = proc_write;
        end else if (req) begin
          state_d = (rd_valid[victim] && rd_dirty[victim]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_write = 1'b1;
        mem_addr  = {rd_tag[victim_q], index};
        if (mem_ready) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        mem_read = 1'b1;
        if (mem_ready) state_d = FILL;
      end
      FILL: begin
        wr_en    = 1'b1;
        wr_way   = victim_q;
        wr_dirty = proc_write;
        lru_en   = 1'b1;
        lru_way  = victim_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (proc_reset) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      wr_en     = 1'b0;
      lru_en    = 1'b0;
    end
  end

  assign mem_wdata  = rd_data[victim_q];
  assign proc_rdata = rd_data[hit_way][{offset, 5'd0} +: 32];
  assign proc_stall = !proc_reset && req && !((state_q == IDLE) && hit);

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q  <= IDLE;
      victim_q <= '0;
      line_q   <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && (state_d != IDLE)) victim_q <= victim;
      if ((state_q == ALLOCATE) && mem_ready) line_q <= mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      for (int unsigned s = 0; s < SETS; s++)
        for (int unsigned w = 0; w < WAYS; w++)
          age_q[s][w] <= WAY_W'(w);
    end else if (lru_en) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == lru_way) age_q[index][w] <= '0;
        else if (age_q[index][w] < age_q[index][lru_way]) age_q[index][w] <= age_q[index][w] + 1'b1;
      end
    end
  end

`ifdef CACHE_PERF_EN
  // retry_q marks the IDLE cycle right after FILL, whose hit completes a miss.
  logic retry_q;

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      retry_q  <= 1'b0;
    end else begin
      if (state_q == FILL) retry_q <= 1'b1;
      else if (state_q == IDLE) retry_q <= 1'b0;
      if ((state_q == IDLE) && req && hit && !retry_q && (hit_cnt != '1))
        hit_cnt <= hit_cnt + 1'b1;
      if ((state_q == IDLE) && (state_d != IDLE) && (miss_cnt != '1))
        miss_cnt <= miss_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Randomised self-checking bench for cache_ctrl_nway against a recency-queue cache model.
module tb_cache_ctrl_nway;

  localparam int unsigned WAYS = 2;
  localparam int unsigned LAT  = 3;

  logic         clk = 1'b0;
  logic         proc_reset, proc_read, proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata, proc_rdata;
  logic         proc_stall, mem_read, mem_write, mem_ready;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
`ifdef CACHE_PERF_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  cache_ctrl_nway #(
    .WAYS   (2),
    .SETS   (4),
    .WORDS  (4),
    .ADDR_W (30)
  ) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
`ifdef CACHE_PERF_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Memory side: mem_img is what the DUT wrote; gold is what the model says memory should hold.
  logic [127:0] mem_img [logic [27:0]];
  logic [127:0] gold    [logic [27:0]];
  int unsigned  lat_cnt = 0;
  bit           spurious = 1'b0;

  typedef struct packed {
    logic [27:0]  la;
    logic         dirty;
    logic [127:0] data;
  } mline_t;
  mline_t cq[$];  // all cached lines, most recently used first

  int unsigned  exp_hits = 0, exp_misses = 0;
  int unsigned  obs_stalls, obs_nrd, obs_nwr;
  logic [27:0]  obs_wba, obs_rda;
  logic [127:0] obs_wbd;
  logic [31:0]  obs_rd;

  function automatic logic [127:0] init_line(input logic [27:0] la);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) begin
      logic [1:0] wi;
      wi = w[1:0];
      l[w*32 +: 32] = {wi, la, 2'b10};
    end
    return l;
  endfunction

  function automatic logic [127:0] gold_line(input logic [27:0] la);
    if (gold.exists(la)) return gold[la];
    return init_line(la);
  endfunction

  function automatic logic [127:0] img_line(input logic [27:0] la);
    if (mem_img.exists(la)) return mem_img[la];
    return init_line(la);
  endfunction

  // Called at posedge+1; drives the memory response for the current cycle.
  task automatic mem_respond();
    #1;
    if (mem_read || mem_write) begin
      lat_cnt++;
      if (lat_cnt == LAT) begin
        lat_cnt   = 0;
        mem_ready = 1'b1;
        if (mem_write) mem_img[mem_addr] = mem_wdata;
        else           mem_rdata = img_line(mem_addr);
      end else begin
        mem_ready = 1'b0;
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end else begin
      lat_cnt   = 0;
      mem_ready = spurious && ($urandom_range(0, 3) == 0);
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic model_reset();
    cq.delete();
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  task automatic do_req(input bit wr, input logic [29:0] addr, input logic [31:0] wd, input string nm);
    logic [27:0]  la;
    logic [1:0]   st;
    int           off, qi, lru_i, cnt;
    bit           hit, wb, done;
    mline_t       e, v;
    logic [27:0]  wba;
    logic [127:0] wbd;
    logic [31:0]  exp_rd;
    int unsigned  exp_stall;
    la = addr[29:2];
    st = la[1:0];
    off = int'(addr[1:0]);
    qi = -1;
    wb = 1'b0;
    for (int i = 0; i < cq.size(); i++) if (cq[i].la == la) qi = i;
    hit = (qi >= 0);
    if (hit) begin
      e = cq[qi];
      cq.delete(qi);
      exp_hits++;
    end else begin
      cnt = 0;
      lru_i = -1;
      for (int i = 0; i < cq.size(); i++) if (cq[i].la[1:0] == st) begin cnt++; lru_i = i; end
      if (cnt == WAYS) begin
        v = cq[lru_i];
        cq.delete(lru_i);
        if (v.dirty) begin
          wb = 1'b1; wba = v.la; wbd = v.data; gold[v.la] = v.data;
        end
      end
      e.la = la; e.dirty = 1'b0; e.data = gold_line(la);
      exp_misses++;
    end
    exp_rd = e.data[off*32 +: 32];
    if (wr) begin e.data[off*32 +: 32] = wd; e.dirty = 1'b1; end
    cq.push_front(e);
    exp_stall = hit ? 0 : 2 + LAT + (wb ? LAT : 0);

    proc_read = !wr; proc_write = wr; proc_addr = addr; proc_wdata = wd;
    obs_stalls = 0; obs_nrd = 0; obs_nwr = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      mem_respond();
      @(negedge clk);
      if (mem_write) begin obs_nwr++; obs_wba = mem_addr; obs_wbd = mem_wdata; end
      if (mem_read) begin obs_nrd++; obs_rda = mem_addr; end
      if (proc_stall) obs_stalls++;
      else begin done = 1'b1; obs_rd = proc_rdata; end
    end
    @(posedge clk); #1;
    proc_read = 1'b0; proc_write = 1'b0;

    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL %s timeout: stall still high after 40 cycles", nm); end
    n_cmp++;
    if (obs_stalls !== exp_stall) begin n_bad++; $display("FAIL %s stall: got %0d want %0d", nm, obs_stalls, exp_stall); end
    n_cmp++;
    if (obs_nrd !== (hit ? 0 : LAT)) begin n_bad++; $display("FAIL %s mem_read cycles: got %0d want %0d", nm, obs_nrd, hit ? 0 : LAT); end
    n_cmp++;
    if (obs_nwr !== (wb ? LAT : 0)) begin n_bad++; $display("FAIL %s mem_write cycles: got %0d want %0d", nm, obs_nwr, wb ? LAT : 0); end
    if (!hit) begin
      n_cmp++;
      if (obs_rda !== la) begin n_bad++; $display("FAIL %s fill addr: got %h want %h", nm, obs_rda, la); end
    end
    if (wb) begin
      n_cmp++;
      if (obs_wba !== wba) begin n_bad++; $display("FAIL %s wb addr: got %h want %h", nm, obs_wba, wba); end
      n_cmp++;
      if (obs_wbd !== wbd) begin n_bad++; $display("FAIL %s wb data: got %h want %h", nm, obs_wbd, wbd); end
    end
    if (!wr) begin
      n_cmp++;
      if (obs_rd !== exp_rd) begin n_bad++; $display("FAIL %s rdata: got %h want %h", nm, obs_rd, exp_rd); end
    end
  endtask

  task automatic apply_reset();
    proc_reset = 1'b1;
    @(posedge clk); #1;
    proc_reset = 1'b0;
    lat_cnt = 0;
    model_reset();
  endtask

  task automatic test_reset();
    proc_read = 1'b1; proc_addr = 30'h0;
    mem_respond();
    @(negedge clk);
    n_cmp++;
    if (proc_stall !== 1'b0) begin n_bad++; $display("FAIL reset stall: got %b want 0", proc_stall); end
    n_cmp++;
    if (mem_read !== 1'b0) begin n_bad++; $display("FAIL reset mem_read: got %b want 0", mem_read); end
    n_cmp++;
    if (mem_write !== 1'b0) begin n_bad++; $display("FAIL reset mem_write: got %b want 0", mem_write); end
    @(posedge clk); #1;
    proc_reset = 1'b0; proc_read = 1'b0;
    model_reset();
  endtask

  task automatic test_clean_miss();
    logic [127:0] l;
    do_req(1'b0, 30'h000, 32'h0, "clean_miss");
    l = init_line(28'h0);
    n_cmp++;
    if (obs_stalls !== 5) begin n_bad++; $display("FAIL clean_miss5 stall: got %0d want 5", obs_stalls); end
    n_cmp++;
    if (obs_rd !== l[31:0]) begin n_bad++; $display("FAIL clean_miss word0: got %h want %h", obs_rd, l[31:0]); end
  endtask

  task automatic test_write_hit();
    do_req(1'b1, 30'h001, 32'hDEADBEEF, "write_hit");
    do_req(1'b0, 30'h001, 32'h0, "read_after_write");
    n_cmp++;
    if (obs_rd !== 32'hDEADBEEF || obs_stalls !== 0 || (obs_nrd + obs_nwr) !== 0) begin
      n_bad++; $display("FAIL write_hit readback: got %h stall %0d strobes %0d want deadbeef 0 0", obs_rd, obs_stalls, obs_nrd + obs_nwr);
    end
  endtask

  task automatic test_dirty_evict();
    do_req(1'b0, 30'h010, 32'h0, "evict_fill");
    do_req(1'b1, 30'h010, 32'hCAFEF00D, "evict_write");
    do_req(1'b0, 30'h000, 32'h0, "evict_touch");
    do_req(1'b0, 30'h020, 32'h0, "evict_miss");
    n_cmp++;
    if (obs_wba !== 28'h4 || obs_wbd[31:0] !== 32'hCAFEF00D) begin
      n_bad++; $display("FAIL dirty_evict wb: got %h/%h want 4/cafef00d", obs_wba, obs_wbd[31:0]);
    end
    n_cmp++;
    if (obs_rda !== 28'h8) begin n_bad++; $display("FAIL dirty_evict fill addr: got %h want 8", obs_rda); end
  endtask

  task automatic test_write_miss();
    do_req(1'b1, 30'h105, 32'h12345678, "write_miss");
    n_cmp++;
    if (obs_nwr !== 0 || obs_nrd !== LAT) begin n_bad++; $display("FAIL write_miss strobes: got wr %0d rd %0d want 0 %0d", obs_nwr, obs_nrd, LAT); end
    do_req(1'b0, 30'h105, 32'h0, "write_miss_read");
    n_cmp++;
    if (obs_rd !== 32'h12345678) begin n_bad++; $display("FAIL write_miss readback: got %h want 12345678", obs_rd); end
    do_req(1'b0, 30'h125, 32'h0, "write_miss_other");
    do_req(1'b0, 30'h145, 32'h0, "write_miss_evict");
    n_cmp++;
    if (obs_wba !== 28'h41 || obs_wbd[63:32] !== 32'h12345678) begin
      n_bad++; $display("FAIL write_miss wb: got %h/%h want 41/12345678", obs_wba, obs_wbd[63:32]);
    end
  endtask

  task automatic test_reset_mid_alloc();
    bit seen_rd;
    do_req(1'b0, 30'h300, 32'h0, "rst_prefill");
    proc_read = 1'b1; proc_addr = 30'h340;
    mem_respond();
    @(negedge clk);
    @(posedge clk); #1;
    mem_respond();
    @(negedge clk);
    seen_rd = mem_read;
    n_cmp++;
    if (seen_rd !== 1'b1) begin n_bad++; $display("FAIL rst_alloc first cycle mem_read: got %b want 1", seen_rd); end
    @(posedge clk); #1;
    proc_reset = 1'b1;
    mem_respond();
    @(negedge clk);
    n_cmp++;
    if (mem_read !== 1'b0 || proc_stall !== 1'b0) begin
      n_bad++; $display("FAIL rst_alloc reset cycle: mem_read %b stall %b want 0 0", mem_read, proc_stall);
    end
    @(posedge clk); #1;
    proc_reset = 1'b0; proc_read = 1'b0;
    lat_cnt = 0;
    model_reset();
    do_req(1'b0, 30'h300, 32'h0, "rst_reread");
    n_cmp++;
    if (obs_nrd !== LAT) begin n_bad++; $display("FAIL rst_alloc reread: mem_read cycles %0d want %0d", obs_nrd, LAT); end
  endtask

`ifdef CACHE_PERF_EN
  task automatic test_perf();
    apply_reset();
    do_req(1'b0, 30'h000, 32'h0, "perf_miss1");
    do_req(1'b0, 30'h000, 32'h0, "perf_hit1");
    do_req(1'b0, 30'h001, 32'h0, "perf_hit2");
    do_req(1'b0, 30'h010, 32'h0, "perf_miss2");
    n_cmp++;
    if (hit_cnt !== 32'd2 || miss_cnt !== 32'd2) begin
      n_bad++; $display("FAIL perf counts: got hit %0d miss %0d want 2 2", hit_cnt, miss_cnt);
    end
  endtask
`endif

  task automatic test_random();
    logic [25:0] tv [4];
    logic [25:0] t;
    logic [1:0]  s, o;
    bit          wr;
    tv[0] = 26'h0; tv[1] = 26'h1; tv[2] = 26'h2A5; tv[3] = 26'h3FFFFFF;
    spurious = 1'b1;
    for (int unsigned i = 0; i < 300; i++) begin
      t  = tv[$urandom_range(0, 3)];
      s  = 2'($urandom_range(0, 3));
      o  = 2'($urandom_range(0, 3));
      wr = ($urandom_range(0, 2) == 0);
      do_req(wr, {t, s, o}, $urandom, "random");
    end
    spurious = 1'b0;
`ifdef CACHE_PERF_EN
    n_cmp++;
    if (hit_cnt !== exp_hits || miss_cnt !== exp_misses) begin
      n_bad++; $display("FAIL random perf: got hit %0d miss %0d want %0d %0d", hit_cnt, miss_cnt, exp_hits, exp_misses);
    end
`endif
  endtask

  task automatic test_back_to_back();
    for (int unsigned i = 0; i < 8; i++)
      do_req(1'b0, (i[0] ? 30'h010 : 30'h000) | 30'(i[2:1]), 32'h0, "back_to_back");
  endtask

  initial begin
    proc_reset = 1'b1; proc_read = 1'b0; proc_write = 1'b0;
    proc_addr = '0; proc_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_clean_miss();
    test_write_hit();
    test_dirty_evict();
    test_write_miss();
    test_reset_mid_alloc();
`ifdef CACHE_PERF_EN
    test_perf();
`endif
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
